// File: rtl/gap_range_gen.sv
// Gap-size generator for new obstacle columns.
// A free-running 8-bit LFSR supplies a sample. On each accepted request the
// sample is reduced modulo range_max by repeated subtraction, one subtract per
// clock. min_gap is then added with saturation, and the result is presented
// for one cycle with a valid pulse.
module gap_range_gen #(
  parameter int         N    = 4,
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [N-1:0] range_max,
  input  logic [N-1:0] min_gap,
  input  logic         test_en,
  input  logic [N-1:0] test_val,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] gap,
  output logic         sat,
  output logic [7:0]   lfsr_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] rem_q, rem_d;
  logic [N-1:0] rng_q, rng_d;
  logic [N-1:0] mn_q, mn_d;
  logic [N-1:0] gap_q, gap_d;
  logic         sat_q, sat_d;
  logic [7:0]   lfsr_d;

  logic [N-1:0] sample;
  logic [N:0]   diff;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic [N:0]   sum;

  // Operand selected at accept: either the directed test value or the low LFSR bits.
  assign sample = test_en ? test_val : lfsr_q[N-1:0];

  // Subtract rem - rng as rem + ~rng + 1. Bit N is the carry-out; it is 1 when no borrow occurs.
  assign diff = {1'b0, rem_q} + {1'b0, ~rng_q} + {{N{1'b0}}, 1'b1};

  // The final adder is shared. In IDLE it runs with rem=0 for the range-zero
  // path. In REDUCE it adds the captured remainder to the captured minimum.
  assign add_a = (state_q == IDLE) ? '0 : rem_q;
  assign add_b = (state_q == IDLE) ? min_gap : mn_q;
  assign sum   = {1'b0, add_a} + {1'b0, add_b};

  // Next LFSR value: Fibonacci taps 8,6,5,4. The all-zero lock-up state reloads the seed.
  always_comb begin
    if (lfsr_q == 8'h00) begin
      lfsr_d = SEED;
    end else begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // FSM next-state and datapath update.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    rem_d   = rem_q;
    rng_d   = rng_q;
    mn_d    = mn_q;
    gap_d   = gap_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          rng_d = range_max;
          mn_d  = min_gap;
          if (range_max == '0) begin
            // A zero modulus skips reduction. The sum here is exactly min_gap and never saturates.
            rem_d   = '0;
            gap_d   = sum[N] ? '1 : sum[N-1:0];
            sat_d   = sum[N];
            state_d = DONE;
          end else begin
            rem_d   = sample;
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        if (diff[N]) begin
          rem_d = diff[N-1:0];
        end else begin
          gap_d   = sum[N] ? '1 : sum[N-1:0];
          sat_d   = sum[N];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and result registers. An async reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      rng_q   <= '0;
      mn_q    <= '0;
      gap_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge values, which matches the hardware.
      state_q <= state_d;
      rem_q   <= rem_d;
      rng_q   <= rng_d;
      mn_q    <= mn_d;
      gap_q   <= gap_d;
      sat_q   <= sat_d;
    end
  end

  // Free-running LFSR. It shifts every clock, independent of the FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign valid = (state_q == DONE);
  assign gap   = gap_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_gap_range_gen.sv
// Directed bench for gap_range_gen.
// Expected results come from an arithmetic model (divide/modulo). They are
// queued when a request is driven and popped when valid appears.
module tb_gap_range_gen;

  logic       clk;
  logic       reset;
  logic       req;
  logic [3:0] range_max;
  logic [3:0] min_gap;
  logic       test_en;
  logic [3:0] test_val;
  logic       ready;
  logic       valid;
  logic [3:0] gap;
  logic       sat;
  logic [7:0] lfsr_q;

  typedef struct {
    logic [3:0] gap;
    logic       sat;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [7:0] m_lfsr;

  gap_range_gen #(.N(4), .SEED(8'h01)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .range_max (range_max),
    .min_gap   (min_gap),
    .test_en   (test_en),
    .test_val  (test_val),
    .ready     (ready),
    .valid     (valid),
    .gap       (gap),
    .sat       (sat),
    .lfsr_q    (lfsr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference LFSR, used for LFSR-sourced samples.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'h01;
    else if (m_lfsr == 8'h00) m_lfsr <= 8'h01;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] s, input logic [3:0] r, input logic [3:0] m);
    exp_t e;
    int   rem;
    int   total;
    if (r == 4'd0) begin
      e.gap = m;
      e.sat = 1'b0;
      e.lat = 1;
    end else begin
      rem   = int'(s) % int'(r);
      total = rem + int'(m);
      e.sat = (total > 15);
      e.gap = e.sat ? 4'hf : total[3:0];
      e.lat = int'(s) / int'(r) + 2;
    end
    return e;
  endfunction

  // Drives one request in an IDLE cycle and queues its expected result.
  task automatic issue(input logic en, input logic [3:0] tv, input logic [3:0] rng,
                       input logic [3:0] mn, input logic hold);
    @(negedge clk);
    check("ready_before_req", ready, 1);
    test_en   = en;
    test_val  = tv;
    range_max = rng;
    min_gap   = mn;
    req       = 1'b1;
    sb.push_back(model(en ? tv : m_lfsr[3:0], rng, mn));
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
  endtask

  // Waits (bounded) for valid after an accept edge and checks it against the queue.
  task automatic wait_result(input string tag);
    int   cnt  = 0;
    logic seen = 1'b0;
    logic rdy  = 1'b0;
    exp_t e;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cnt++;
      if (valid) seen = 1'b1;
      else if (ready) rdy = 1'b1;
    end
    if (sb.size() == 0) begin
      check({tag, "_queue_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid_seen"}, seen, 1);
    check({tag, "_latency"}, cnt, e.lat);
    check({tag, "_gap"}, gap, e.gap);
    check({tag, "_sat"}, sat, e.sat);
    check({tag, "_not_ready_busy"}, rdy, 0);
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, valid, 0);
    check({tag, "_ready_after"}, ready, 1);
    check({tag, "_gap_hold"}, gap, e.gap);
    check({tag, "_sat_hold"}, sat, e.sat);
  endtask

  initial begin
    logic [7:0] exp_l [4];
    logic       vseen;
    exp_l = '{8'h02, 8'h04, 8'h08, 8'h11};
    reset = 1'b1; req = 1'b0; range_max = '0; min_gap = '0; test_en = 1'b0; test_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_lfsr", lfsr_q, 8'h01);
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_gap", gap, 0);
    check("rst_sat", sat, 0);
    reset = 1'b0;

    // The LFSR sequence from the seed, with the FSM idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lfsr_seq", lfsr_q, exp_l[i]);
      check("idle_ready", ready, 1);
      check("idle_valid", valid, 0);
      check("idle_gap", gap, 0);
    end

    // 13 mod 4 takes 3 subtracts: 1 + 2 = 3.
    issue(1'b1, 4'd13, 4'd4, 4'd2, 1'b0);
    wait_result("mod13_4");

    // No subtract. 3 + 14 saturates.
    issue(1'b1, 4'd3, 4'd5, 4'd14, 1'b0);
    wait_result("sat_3_5");

    // A zero range returns min_gap after one cycle.
    issue(1'b1, 4'd9, 4'd0, 4'd6, 1'b0);
    wait_result("range0");

    // Full range: 15 mod 15 = 0, so the gap equals min_gap.
    issue(1'b1, 4'd15, 4'd15, 4'd7, 1'b0);
    wait_result("mod15_15");

    // LFSR-sourced sample.
    issue(1'b0, 4'd0, 4'd3, 4'd5, 1'b0);
    wait_result("lfsr_sample");

    // Worst case range 1, with reset asserted 5 cycles in.
    issue(1'b1, 4'd15, 4'd1, 4'd0, 1'b0);
    void'(sb.pop_back());
    vseen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid) vseen = 1'b1;
    end
    check("abort_no_valid_before", vseen, 0);
    reset = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_valid", valid, 0);
    check("abort_gap", gap, 0);
    check("abort_sat", sat, 0);
    check("abort_lfsr", lfsr_q, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    check("abort_valid_held", valid, 0);

    // A worst-case request after reset runs all 15 subtracts.
    issue(1'b1, 4'd15, 4'd1, 4'd0, 1'b0);
    wait_result("worst_range1");

    // req held high: operands change after the accept, and the second request follows DONE.
    issue(1'b1, 4'd9, 4'd2, 4'd3, 1'b1);
    range_max = 4'd3;
    min_gap   = 4'd1;
    test_val  = 4'd7;
    sb.push_back(model(4'd7, 4'd3, 4'd1));
    wait_result("hold_first");
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_result("hold_second");

    check("lfsr_track", lfsr_q, m_lfsr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gap_range_gen.md
Name: gap_range_gen

Overview:
- Sequential generator for the pipe gap size of each new obstacle column.
- Samples a free-running LFSR and reduces the sample modulo a programmable range by repeated subtraction, one subtract per clock.
- Adds a minimum gap with saturation and returns the result over a req/ready/valid handshake.
- Sits between the obstacle spawner (requester) and the pipe renderer.

Parameters:
- N, 4, width of range, min gap, sample and result.
- SEED, 8'h01, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request a new gap; accepted when req && ready at a rising edge.
- range_max  input  N  modulus; sampled at accept.
- min_gap  input  N  offset added after reduction; sampled at accept.
- test_en  input  1  at accept, use test_val instead of the LFSR sample.
- test_val  input  N  directed sample for verification.
- ready  output  1  high only in IDLE.
- valid  output  1  one-cycle pulse; gap and sat are valid while it is high.
- gap  output  N  result; holds its value until the next DONE.
- sat  output  1  high when the final add saturated; holds like gap.
- lfsr_q  output  8  current LFSR state, for debug.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, ready=1, valid=0, gap=0, sat=0, lfsr_q=SEED, internal rem/range/min registers=0.
- LFSR:
  - 8-bit Fibonacci, shifts every clock regardless of state: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - If lfsr ever reads 0, reload SEED on the next edge.
- Sample at accept is lfsr[N-1:0], or test_val when test_en=1.
- States: IDLE, REDUCE, DONE.
- IDLE:
  - On req && ready, capture sample into rem, range_max into rng, min_gap into mn.
  - If range_max==0, force rem=0 and go to DONE.
  - Otherwise go to REDUCE.
- REDUCE, evaluated each cycle:
  - Compute rem - rng as an N+1-bit subtract, i.e. rem + ~rng + 1; carry-out=1 means no borrow (rem >= rng).
  - No borrow: rem <= rem - rng, stay in REDUCE.
  - Borrow: compute the N+1-bit sum s = rem + mn.
    - gap <= s[N] ? all-ones : s[N-1:0].
    - sat <= s[N].
    - Go to DONE.
- DONE: valid=1 for exactly this cycle; next state IDLE.
- Range-zero path: the same add runs with rem=0 on the IDLE->DONE transition, so gap=min_gap and sat=0.
- Latency:
  - With k = floor(sample / range_max), valid is high in the (k+2)th cycle after the accept edge.
  - With range_max==0, valid is high in the first cycle after the accept edge.
- Handshake:
  - req while ready=0 is ignored and not queued.
  - range_max, min_gap and test inputs may change freely after accept without effect.
  - req may stay high continuously; a new accept occurs on the first IDLE cycle after DONE.
- Worst case: range_max=1 gives k = 2^N - 1 subtractions.
- Reset mid-operation: immediate return to IDLE; the in-flight result is discarded; valid stays 0; gap, sat and lfsr_q return to their reset values.

Test Plan:
- Reset with SEED=8'h01, clock 4 edges -> lfsr_q reads 02, 04, 08, 11; ready=1, valid=0, gap=0 throughout.
- test_en=1, test_val=13, range_max=4, min_gap=2, req pulse -> 3 subtracts (13→9→5→1); valid high exactly in the 5th cycle after the accept edge; gap=3, sat=0; ready=1 the cycle after.
- test_val=3, range_max=5, min_gap=14 -> no subtract; valid in the 2nd cycle after accept; gap=15, sat=1.
- range_max=0, min_gap=6, test_val=9 -> valid in the 1st cycle after accept; gap=6, sat=0.
- test_val=15, range_max=1, accept, then assert reset 5 cycles in -> valid never pulses; ready=1, gap=0, sat=0, lfsr_q=SEED; after reset release, a new accept completes normally.
- Hold req high during REDUCE with different range_max/min_gap -> no new accept until IDLE; the first result reflects the originally captured operands; the second request starts on the cycle after DONE.
